// File: rtl/ps2_ascii_decoder.sv
// ps2_ascii_decoder
//   Turns the raw PS/2 Set-2 byte stream into case-correct ASCII. Tracks the
//   F0 (break) and E0 (extended) prefixes, the Shift/Ctrl/CapsLock state, and
//   buffers produced characters in a small valid/ready output FIFO.
//
// Ports
//   clock, reset_n         system clock (rising edge), async active-low reset
//   scan_valid, scan_data  one-cycle strobe with a received scancode byte
//   ascii_data/valid/ready FIFO head, non-empty flag, consumer accept
//   caps_lock              CapsLock toggle state (LED)
//   shift_held, ctrl_held  live modifier state
//   overflow, ovf_clr      sticky "character dropped on full FIFO", clear
//   fifo_count             occupied FIFO entries
//
// Prefix FSM
//   state     | meaning
//   S_IDLE    | no prefix pending; next byte is a plain make or a prefix
//   S_BRK     | F0 seen; next byte is a break code
//   S_EXT     | E0 seen; next byte is an extended make, or F0
//   S_EXT_BRK | E0 F0 seen; next byte is an extended break code
module ps2_ascii_decoder #(
  parameter int FIFO_DEPTH  = 4,
  parameter bit ENABLE_CTRL = 1'b1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          scan_valid,
  input  logic [7:0]                    scan_data,
  output logic [7:0]                    ascii_data,
  output logic                          ascii_valid,
  input  logic                          ascii_ready,
  output logic                          caps_lock,
  output logic                          shift_held,
  output logic                          ctrl_held,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_e;

  state_e state_q, state_d;
  logic   key_evt, key_make, key_ext;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (scan_valid) begin
      case (state_q)
        S_IDLE:    if (scan_data == 8'hF0)      state_d = S_BRK;
                   else if (scan_data == 8'hE0) state_d = S_EXT;
        S_BRK:     state_d = S_IDLE;
        S_EXT:     state_d = (scan_data == 8'hF0) ? S_EXT_BRK : S_IDLE;
        S_EXT_BRK: state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Key event decode: a complete make or break with its extended flag.
  always_comb begin
    key_evt  = 1'b0;
    key_make = 1'b0;
    key_ext  = 1'b0;
    if (scan_valid) begin
      case (state_q)
        S_IDLE: if (scan_data != 8'hF0 && scan_data != 8'hE0) begin
          key_evt  = 1'b1;
          key_make = 1'b1;
        end
        S_BRK: key_evt = 1'b1;
        S_EXT: if (scan_data != 8'hF0) begin
          key_evt  = 1'b1;
          key_make = 1'b1;
          key_ext  = 1'b1;
        end
        S_EXT_BRK: begin
          key_evt = 1'b1;
          key_ext = 1'b1;
        end
        default: ;
      endcase
    end
  end

  logic lshift_q, rshift_q, lctrl_q, rctrl_q, caps_q, caps_held_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
    end else if (key_evt) begin
      case (scan_data)
        8'h12: if (!key_ext) lshift_q <= key_make;  // E0 12 is a fake shift
        8'h59: rshift_q <= key_make;
        8'h14: if (key_ext) rctrl_q <= key_make;
               else         lctrl_q <= key_make;
        8'h58: begin
          // Only the first make of a hold toggles; typematic repeats do not.
          if (key_make && !caps_held_q) caps_q <= ~caps_q;
          caps_held_q <= key_make;
        end
        default: ;
      endcase
    end
  end

  assign shift_held = lshift_q | rshift_q;
  assign ctrl_held  = lctrl_q | rctrl_q;
  assign caps_lock  = caps_q;

  // Translation uses the modifier state as it was before this byte.
  logic [7:0] lc, dig, dig_sh, char;
  logic       char_vld;

  always_comb begin
    lc = 8'h00;
    case (scan_data)
      8'h1C: lc = "a"; 8'h32: lc = "b"; 8'h21: lc = "c"; 8'h23: lc = "d";
      8'h24: lc = "e"; 8'h2B: lc = "f"; 8'h34: lc = "g"; 8'h33: lc = "h";
      8'h43: lc = "i"; 8'h3B: lc = "j"; 8'h42: lc = "k"; 8'h4B: lc = "l";
      8'h3A: lc = "m"; 8'h31: lc = "n"; 8'h44: lc = "o"; 8'h4D: lc = "p";
      8'h15: lc = "q"; 8'h2D: lc = "r"; 8'h1B: lc = "s"; 8'h2C: lc = "t";
      8'h3C: lc = "u"; 8'h2A: lc = "v"; 8'h1D: lc = "w"; 8'h22: lc = "x";
      8'h35: lc = "y"; 8'h1A: lc = "z";
      default: lc = 8'h00;
    endcase
  end

  always_comb begin
    dig    = 8'h00;
    dig_sh = 8'h00;
    case (scan_data)
      8'h16: begin dig = "1"; dig_sh = "!"; end
      8'h1E: begin dig = "2"; dig_sh = "@"; end
      8'h26: begin dig = "3"; dig_sh = "#"; end
      8'h25: begin dig = "4"; dig_sh = "$"; end
      8'h2E: begin dig = "5"; dig_sh = "%"; end
      8'h36: begin dig = "6"; dig_sh = "^"; end
      8'h3D: begin dig = "7"; dig_sh = "&"; end
      8'h3E: begin dig = "8"; dig_sh = "*"; end
      8'h46: begin dig = "9"; dig_sh = "("; end
      8'h45: begin dig = "0"; dig_sh = ")"; end
      default: ;
    endcase
  end

  always_comb begin
    char_vld = 1'b0;
    char     = 8'h00;
    if (key_make && !key_ext) begin
      if (lc != 8'h00) begin
        char_vld = 1'b1;
        if (ENABLE_CTRL && ctrl_held)     char = lc & 8'h1F;
        else if (shift_held ^ caps_q)     char = lc & 8'hDF;
        else                              char = lc;
      end else if (dig != 8'h00) begin
        char_vld = 1'b1;
        char     = shift_held ? dig_sh : dig;
      end else begin
        case (scan_data)
          8'h29: begin char_vld = 1'b1; char = 8'h20; end
          8'h5A: begin char_vld = 1'b1; char = 8'h0D; end
          8'h66: begin char_vld = 1'b1; char = 8'h08; end
          8'h0D: begin char_vld = 1'b1; char = 8'h09; end
          default: ;
        endcase
      end
    end else if (key_make && key_ext && scan_data == 8'h5A) begin
      char_vld = 1'b1;
      char     = 8'h0D;
    end
  end

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, push, pop, drop;

  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign ascii_valid = (count_q != '0);
  assign pop         = ascii_valid & ascii_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push        = char_vld & (~full | pop);
  assign drop        = char_vld & full & ~pop;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= char;
  end

  assign ascii_data = ascii_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
module tb_ps2_ascii_decoder;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       scan_valid, ascii_ready, ovf_clr;
  logic [7:0] scan_data;
  logic [7:0] ascii_data;
  logic       ascii_valid, caps_lock, shift_held, ctrl_held, overflow;
  logic [2:0] fifo_count;

  ps2_ascii_decoder #(.FIFO_DEPTH(DEPTH), .ENABLE_CTRL(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .scan_valid(scan_valid), .scan_data(scan_data),
    .ascii_data(ascii_data), .ascii_valid(ascii_valid), .ascii_ready(ascii_ready),
    .caps_lock(caps_lock), .shift_held(shift_held), .ctrl_held(ctrl_held),
    .overflow(overflow), .ovf_clr(ovf_clr), .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] recv_q[$];

  // Reference model state, in terms of keys rather than decoder states.
  bit saw_f0, saw_e0;
  bit lsh, rsh, lctl, rctl, caps, caps_down, m_ovf;

  logic [7:0] letter_codes [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                    8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                    8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] digit_codes [10] = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45};
  string digit_plain = "1234567890";
  string digit_shift = "!@#$%^&*()";
  logic [7:0] mod_codes  [4] = '{8'h12,8'h59,8'h14,8'h58};
  logic [7:0] spec_codes [4] = '{8'h29,8'h5A,8'h66,8'h0D};

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    saw_f0 = 0; saw_e0 = 0;
    lsh = 0; rsh = 0; lctl = 0; rctl = 0; caps = 0; caps_down = 0; m_ovf = 0;
  endtask

  // Effect of one complete key event on the model; returns any character.
  task automatic key_event(input logic [7:0] code, input bit make, input bit ext,
                           output bit emit, output logic [7:0] ch);
    bit sh, ct;
    emit = 0; ch = 8'h00;
    sh = lsh || rsh;
    ct = lctl || rctl;
    if (make && !ext) begin
      for (int i = 0; i < 26; i++)
        if (code == letter_codes[i]) begin
          emit = 1;
          if (ct)                  ch = 8'(i + 1);
          else if (sh != caps)     ch = 8'(8'h41 + i);
          else                     ch = 8'(8'h61 + i);
        end
      for (int i = 0; i < 10; i++)
        if (code == digit_codes[i]) begin
          emit = 1;
          ch = sh ? digit_shift[i] : digit_plain[i];
        end
      if (code == 8'h29) begin emit = 1; ch = 8'h20; end
      if (code == 8'h5A) begin emit = 1; ch = 8'h0D; end
      if (code == 8'h66) begin emit = 1; ch = 8'h08; end
      if (code == 8'h0D) begin emit = 1; ch = 8'h09; end
    end else if (make && ext && code == 8'h5A) begin
      emit = 1; ch = 8'h0D;
    end
    if (code == 8'h12 && !ext) lsh = make;
    if (code == 8'h59) rsh = make;
    if (code == 8'h14) begin
      if (ext) rctl = make; else lctl = make;
    end
    if (code == 8'h58) begin
      if (make && !caps_down) caps = !caps;
      caps_down = make;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, output bit emit, output logic [7:0] ch);
    emit = 0; ch = 8'h00;
    if (saw_f0) begin
      key_event(b, 1'b0, saw_e0, emit, ch);
      saw_f0 = 0; saw_e0 = 0;
    end else if (saw_e0) begin
      if (b == 8'hF0) saw_f0 = 1;
      else begin
        key_event(b, 1'b1, 1'b1, emit, ch);
        saw_e0 = 0;
      end
    end else if (b == 8'hF0) saw_f0 = 1;
    else if (b == 8'hE0) saw_e0 = 1;
    else key_event(b, 1'b1, 1'b0, emit, ch);
  endtask

  task automatic check_state();
    chk("fifo_count", int'(fifo_count), exp_q.size());
    chk("ascii_valid", int'(ascii_valid), int'(exp_q.size() > 0));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("caps_lock", int'(caps_lock), int'(caps));
    chk("shift_held", int'(shift_held), int'(lsh || rsh));
    chk("ctrl_held", int'(ctrl_held), int'(lctl || rctl));
  endtask

  // One clock: check state left by the previous edge, drive, predict.
  task automatic cyc(input bit v, input logic [7:0] d, input bit r, input bit c);
    bit emit, popping, dropped;
    logic [7:0] ch;
    @(posedge clock); #1;
    check_state();
    scan_valid = v; scan_data = d; ascii_ready = r; ovf_clr = c;
    emit = 0; ch = 8'h00; dropped = 0;
    if (v) model_byte(d, emit, ch);
    popping = (exp_q.size() > 0) && r;
    if (emit) begin
      if (exp_q.size() < DEPTH || popping) exp_q.push_back(ch);
      else dropped = 1;
    end
    if (dropped)  m_ovf = 1;
    else if (c)   m_ovf = 0;
  endtask

  task automatic send(input logic [7:0] b, input bit r);
    cyc(1'b1, b, r, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic expect_seq(input string nm, input logic [7:0] e [5], input int n);
    chk({nm, "_len"}, recv_q.size(), n);
    for (int i = 0; i < n && i < recv_q.size(); i++)
      chk($sformatf("%s_%0d", nm, i), int'(recv_q[i]), int'(e[i]));
    recv_q.delete();
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_valid"}, int'(ascii_valid), 0);
    chk({nm, "_count"}, int'(fifo_count), 0);
    chk({nm, "_data"}, int'(ascii_data), 0);
    chk({nm, "_caps"}, int'(caps_lock), 0);
    chk({nm, "_shift"}, int'(shift_held), 0);
    chk({nm, "_ctrl"}, int'(ctrl_held), 0);
    chk({nm, "_ovf"}, int'(overflow), 0);
  endtask

  // Monitor: the DUT pops at the next rising edge when valid && ready.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clock);
      if (reset_n && ascii_valid && ascii_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_char: got 0x%0h expected none", ascii_data);
        end else begin
          e = exp_q.pop_front();
          chk("ascii_data", int'(ascii_data), int'(e));
          recv_q.push_back(ascii_data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    logic [7:0] b;
    reset_n = 1'b0; scan_valid = 1'b0; scan_data = 8'h00; ascii_ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    #3;
    check_reset_outputs("rst0");
    @(posedge clock); #1; reset_n = 1'b1;

    // 1C, F0 1C: single 'a' visible the cycle after the strobe.
    send(8'h1C, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t1_valid", int'(ascii_valid), 1);
    chk("t1_data", int'(ascii_data), 8'h61);
    chk("t1_count", int'(fifo_count), 1);
    send(8'hF0, 1'b0); send(8'h1C, 1'b0);
    drain();
    expect_seq("t1", '{8'h61, 0, 0, 0, 0}, 1);

    // Shift make/break around letters.
    send(8'h12, 1'b1);
    send(8'h1C, 1'b1);
    chk("t2_shift_on", int'(shift_held), 1);
    send(8'hF0, 1'b1); send(8'h1C, 1'b1); send(8'hF0, 1'b1); send(8'h12, 1'b1);
    send(8'h1C, 1'b1);
    chk("t2_shift_off", int'(shift_held), 0);
    drain();
    expect_seq("t2", '{8'h41, 8'h61, 0, 0, 0}, 2);

    // CapsLock with typematic repeat, then caps+shift cancel.
    send(8'h58, 1'b1); send(8'h58, 1'b1);
    chk("t3_caps_on", int'(caps_lock), 1);
    send(8'hF0, 1'b1); send(8'h58, 1'b1); send(8'h1C, 1'b1);
    chk("t3_caps_held", int'(caps_lock), 1);
    send(8'h58, 1'b1); send(8'hF0, 1'b1); send(8'h58, 1'b1);
    send(8'h12, 1'b1); send(8'h1C, 1'b1);
    chk("t3_caps_off", int'(caps_lock), 0);
    send(8'hF0, 1'b1); send(8'h12, 1'b1);
    drain();
    expect_seq("t3", '{8'h41, 8'h41, 0, 0, 0}, 2);

    // Fake shift ignored; right Ctrl gives control codes.
    send(8'hE0, 1'b1); send(8'h12, 1'b1); send(8'h16, 1'b1);
    chk("t4_fake_shift", int'(shift_held), 0);
    send(8'hE0, 1'b1); send(8'h14, 1'b1); send(8'h21, 1'b1);
    chk("t4_ctrl_on", int'(ctrl_held), 1);
    send(8'hE0, 1'b1); send(8'hF0, 1'b1); send(8'h14, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_ctrl_off", int'(ctrl_held), 0);
    drain();
    expect_seq("t4", '{8'h31, 8'h03, 0, 0, 0}, 2);

    // Overflow on a stalled FIFO, then push+pop on full.
    send(8'h1C, 1'b0); send(8'h32, 1'b0); send(8'h21, 1'b0); send(8'h23, 1'b0);
    send(8'h24, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t5_full_count", int'(fifo_count), 4);
    chk("t5_ovf", int'(overflow), 1);
    send(8'h2B, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t5_count_kept", int'(fifo_count), 4);
    drain();
    expect_seq("t5", '{8'h61, 8'h62, 8'h63, 8'h64, 8'h66}, 5);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t5_ovf_clr", int'(overflow), 0);

    // Randomised byte stream against the model.
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: b = letter_codes[$urandom_range(0, 25)];
        4:          b = digit_codes[$urandom_range(0, 9)];
        5:          b = mod_codes[$urandom_range(0, 3)];
        6:          b = 8'hF0;
        7:          b = 8'hE0;
        8:          b = spec_codes[$urandom_range(0, 3)];
        default:    b = 8'($urandom);
      endcase
      cyc(($urandom_range(0, 9) < 7), b, ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
    end
    drain();
    recv_q.delete();

    // Reset after a pending F0 with modifiers active.
    send(8'h58, 1'b0); send(8'hF0, 1'b0); send(8'h58, 1'b0);
    send(8'h12, 1'b0); send(8'h1C, 1'b0); send(8'hF0, 1'b0);
    @(posedge clock); #1;
    reset_n = 1'b0; scan_valid = 1'b0; ascii_ready = 1'b0;
    #2;
    check_reset_outputs("rst_mid");
    model_reset();
    exp_q.delete();
    recv_q.delete();
    @(posedge clock); #1;
    check_reset_outputs("rst_hold");
    reset_n = 1'b1;
    send(8'h1C, 1'b0);
    drain();
    expect_seq("t6", '{8'h61, 0, 0, 0, 0}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
